// File: rtl/gpr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpr_pkg
// Description : Shared constants, address-width helper and register-array
//               type for the gpr_bank_mp register bank.
// Revision    : 1.0 - initial release
// ============================================================================
package gpr_pkg;

  localparam int GPR_DATA_W_DEF   = 16;
  localparam int GPR_NUM_REGS_DEF = 16;

  // Index width for a bank of num_regs entries; never narrower than one bit.
  function automatic int gpr_addr_w(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  // Register array at the default geometry.
  typedef logic [GPR_DATA_W_DEF-1:0] gpr_array_t [GPR_NUM_REGS_DEF];

endpackage : gpr_pkg
`default_nettype wire

// File: rtl/gpr_rd_port.sv
`default_nettype none
// ============================================================================
// Module      : gpr_rd_port
// Description : One combinational read port of the register bank. Range-checks
//               the index, selects the register and, when GPR_BYPASS_EN is
//               defined, forwards the value the coming edge will store.
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_rd_port
  import gpr_pkg::*;
#(
  parameter  int DATA_W   = GPR_DATA_W_DEF,
  parameter  int NUM_REGS = GPR_NUM_REGS_DEF,
  localparam int ADDR_W   = gpr_addr_w(NUM_REGS)
) (
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat_i,
  input  logic [ADDR_W-1:0]          rd_addr_i,
  input  logic                       clr_i,
  input  logic                       wr_eff_i,
  input  logic [ADDR_W-1:0]          wr_addr_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       inc_eff_i,
  input  logic [ADDR_W-1:0]          inc_addr_i,
  output logic [DATA_W-1:0]          rd_data_o
);

  logic              addr_ok;
  logic [DATA_W-1:0] sel;

  // A full power-of-two bank has no unused indices to reject.
  generate
    if (NUM_REGS == (1 << ADDR_W)) begin : g_full_range
      assign addr_ok = 1'b1;
    end else begin : g_part_range
      assign addr_ok = (32'(rd_addr_i) < 32'(NUM_REGS));
    end
  endgenerate

  // Select the addressed register from the flattened storage.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr_i == ADDR_W'(i)) sel = regs_flat_i[i*DATA_W +: DATA_W];
    end
  end

`ifdef GPR_BYPASS_EN
  // Forward next-edge value with the bank's own priority: clr > write > inc.
  always_comb begin
    if (clr_i || !addr_ok)                         rd_data_o = '0;
    else if (wr_eff_i && (rd_addr_i == wr_addr_i))   rd_data_o = wr_data_i;
    else if (inc_eff_i && (rd_addr_i == inc_addr_i)) rd_data_o = sel + DATA_W'(1);
    else                                           rd_data_o = sel;
  end
`else
  assign rd_data_o = addr_ok ? sel : '0;

  // Forwarding inputs have no role when reads show stored contents only.
  logic unused_bypass;
  assign unused_bypass = ^{clr_i, wr_eff_i, wr_addr_i, wr_data_i, inc_eff_i, inc_addr_i};
`endif

endmodule : gpr_rd_port
`default_nettype wire

// File: rtl/gpr_bank_mp.sv
`default_nettype none
// ============================================================================
// Module      : gpr_bank_mp
// Description : Parametrised general-purpose register bank with two
//               combinational read ports, one write port, a pointer increment
//               port, synchronous bulk clear and a registered wrap pulse.
//               Define GPR_BYPASS_EN to forward next-edge values to reads.
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_bank_mp
  import gpr_pkg::*;
#(
  parameter  int DATA_W   = GPR_DATA_W_DEF,
  parameter  int NUM_REGS = GPR_NUM_REGS_DEF,
  localparam int ADDR_W   = gpr_addr_w(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              inc_en,
  input  logic [ADDR_W-1:0] inc_addr,
  input  logic              clr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              inc_wrap
);

  logic [DATA_W-1:0]          regs_q [NUM_REGS];
  logic [DATA_W-1:0]          regs_d [NUM_REGS];
  logic                       inc_wrap_q;
  logic                       inc_wrap_d;
  logic                       wr_addr_ok;
  logic                       inc_addr_ok;
  logic                       wr_eff;
  logic                       inc_eff;
  logic [DATA_W-1:0]          inc_old;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;

  // Out-of-range indices only exist when NUM_REGS is not a power of two.
  generate
    if (NUM_REGS == (1 << ADDR_W)) begin : g_full_range
      assign wr_addr_ok  = 1'b1;
      assign inc_addr_ok = 1'b1;
    end else begin : g_part_range
      assign wr_addr_ok  = (32'(wr_addr)  < 32'(NUM_REGS));
      assign inc_addr_ok = (32'(inc_addr) < 32'(NUM_REGS));
    end
  endgenerate

  // A write to the same register swallows the increment (and its wrap).
  assign wr_eff  = wr_en && wr_addr_ok;
  assign inc_eff = inc_en && inc_addr_ok && !(wr_eff && (wr_addr == inc_addr));

  // Current value of the increment target, used for the wrap test.
  always_comb begin
    inc_old = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (inc_addr == ADDR_W'(i)) inc_old = regs_q[i];
    end
  end

  // Next state per register: clear beats write beats increment.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (clr)                                     regs_d[i] = '0;
      else if (wr_eff && (wr_addr == ADDR_W'(i)))   regs_d[i] = wr_data;
      else if (inc_eff && (inc_addr == ADDR_W'(i))) regs_d[i] = regs_q[i] + DATA_W'(1);
    end
    inc_wrap_d = !clr && inc_eff && (&inc_old);
  end

  // Storage and wrap flag; asynchronous clear to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      inc_wrap_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      inc_wrap_q <= inc_wrap_d;
    end
  end

  assign inc_wrap = inc_wrap_q;

  // Flatten storage so each read port sees a plain vector.
  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end
  endgenerate

  gpr_rd_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_rd_a (
    .regs_flat_i (regs_flat),
    .rd_addr_i   (rd_addr_a),
    .clr_i       (clr),
    .wr_eff_i    (wr_eff),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .inc_eff_i   (inc_eff),
    .inc_addr_i  (inc_addr),
    .rd_data_o   (rd_data_a)
  );

  gpr_rd_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_rd_b (
    .regs_flat_i (regs_flat),
    .rd_addr_i   (rd_addr_b),
    .clr_i       (clr),
    .wr_eff_i    (wr_eff),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .inc_eff_i   (inc_eff),
    .inc_addr_i  (inc_addr),
    .rd_data_o   (rd_data_b)
  );

endmodule : gpr_bank_mp
`default_nettype wire
